// File: rtl/conv3x3_mac_slave.sv
// rtl/conv3x3_mac_slave.sv - Avalon-MM slave computing a 3x3 signed dot product plus bias.
// Optional ReLU on the result is built when CONV_RELU_EN is defined.
module conv3x3_mac_slave #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0]   w_reg [9];
    logic signed [DATA_W-1:0]   p_reg [9];
    logic signed [ACC_W-1:0]    bias_reg;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    result_reg;
    logic signed [ACC_W-1:0]    acc_final;
    logic signed [DATA_W-1:0]   cur_w;
    logic signed [DATA_W-1:0]   cur_p;
    logic signed [2*DATA_W-1:0] prod;
    logic [3:0]                 idx;
    logic                       fin_stage;
    logic                       done;
    logic                       relu_rd;
    logic                       busy;
    logic                       wr_en;
    logic                       rd_en;
    logic                       cfg_wr;
    logic                       start_req;
    logic                       load;
    logic                       mac_en;
    logic                       capture;
    logic                       set_done;
    logic [31:0]                rd_mux;

    assign wr_en     = chipselect & write;
    assign rd_en     = chipselect & read;
    assign busy      = (state != IDLE);
    assign cfg_wr    = wr_en & ~busy;
    assign start_req = cfg_wr & (address == 5'd19) & writedata[0];
    assign irq       = done;

    always_comb begin
        cur_w = '0;
        cur_p = '0;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) begin
                cur_w = w_reg[i];
                cur_p = p_reg[i];
            end
        end
    end

    assign prod = cur_w * cur_p;

`ifdef CONV_RELU_EN
    logic relu_en;
    assign relu_rd   = relu_en;
    assign acc_final = (relu_en && acc[ACC_W-1]) ? '0 : acc;
`else
    assign relu_rd   = 1'b0;
    assign acc_final = acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FINISH spans two cycles: result capture, then the done/busy handoff,
    // which places done on the 11th edge after the start write.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        mac_en     = 1'b0;
        capture    = 1'b0;
        set_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    load       = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (idx == 4'd8) state_next = FINISH;
            end
            FINISH: begin
                if (!fin_stage) begin
                    capture = 1'b1;
                end else begin
                    set_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                w_reg[i] <= '0;
                p_reg[i] <= '0;
            end
            bias_reg   <= '0;
            acc        <= '0;
            result_reg <= '0;
            idx        <= '0;
            fin_stage  <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (cfg_wr) begin
                for (int i = 0; i < 9; i++) begin
                    if (address == 5'(i))     w_reg[i] <= writedata[DATA_W-1:0];
                    if (address == 5'(i + 9)) p_reg[i] <= writedata[DATA_W-1:0];
                end
                if (address == 5'd18) bias_reg <= ACC_W'($signed(writedata));
            end

            if (load) begin
                acc <= bias_reg;
                idx <= '0;
            end else if (mac_en) begin
                acc <= acc + ACC_W'(prod);
                idx <= idx + 4'd1;
            end

            if (capture)       fin_stage <= 1'b1;
            else if (set_done) fin_stage <= 1'b0;

            if (capture) result_reg <= acc_final;

            // A clear arriving with the FINISH handoff loses to the set.
            if (load)
                done <= 1'b0;
            else if (set_done)
                done <= 1'b1;
            else if (wr_en && address == 5'd20 && writedata[1])
                done <= 1'b0;
        end
    end

`ifdef CONV_RELU_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            relu_en <= 1'b0;
        else if (cfg_wr && address == 5'd19)  relu_en <= writedata[1];
    end
`endif

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < 9; i++) begin
            if (address == 5'(i))     rd_mux = 32'(w_reg[i]);
            if (address == 5'(i + 9)) rd_mux = 32'(p_reg[i]);
        end
        case (address)
            5'd18:   rd_mux = 32'(bias_reg);
            5'd19:   rd_mux = {30'd0, relu_rd, 1'b0};
            5'd20:   rd_mux = {30'd0, done, busy};
            5'd21:   rd_mux = 32'(result_reg);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      readdata <= '0;
        else if (rd_en) readdata <= rd_mux;
    end

endmodule

// File: tb/tb_conv3x3_mac_slave.sv
// tb/tb_conv3x3_mac_slave.sv - self-checking bench for conv3x3_mac_slave.
module tb_conv3x3_mac_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    always #10 clk = ~clk;

    conv3x3_mac_slave #(.DATA_W(8), .ACC_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        logic [8:0][7:0] w;
        logic [8:0][7:0] p;
        logic [31:0]     bias;
        logic            relu;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs [10];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [31:0] model(input vec_t v);
        int acc;
        acc = int'(v.bias);
        for (int i = 0; i < 9; i++)
            acc += int'($signed(v.w[i])) * int'($signed(v.p[i]));
`ifdef CONV_RELU_EN
        if (v.relu && acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 9; i++) begin
            bus_write(5'(i), {{24{v.w[i][7]}}, v.w[i]});
            bus_write(5'(i + 9), {$urandom_range(0, 255), 16'h0, v.p[i]});
        end
        bus_write(5'd18, v.bias);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int          cyc;
        logic [31:0] d;
        load_vec(v);
        bus_write(5'd19, {30'd0, v.relu, 1'b1});
        wait_done(cyc);
        check({name, "_latency"}, 32'(cyc), 32'd11);
        bus_read(5'd20, d);
        check({name, "_status"}, d, 32'h2);
        bus_read(5'd21, d);
        check({name, "_result"}, d, v.exp);
        bus_write(5'd20, 32'h2);
        check({name, "_irq_clr"}, {31'd0, irq}, 32'd0);
        bus_read(5'd21, d);
        check({name, "_result_hold"}, d, v.exp);
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;

        vecs[0].w = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].p = {9{8'd1}};
        vecs[0].bias = 32'd0;
        vecs[0].relu = 1'b0;
        vecs[0].exp  = 32'd45;
        vecs[1].w = {9{8'h80}};
        vecs[1].p = {9{8'h7F}};
        vecs[1].bias = 32'hFFFF_FFFB;
        vecs[1].relu = 1'b0;
        vecs[1].exp  = 32'hFFFD_C47B;
        vecs[2].w = {{8{8'd0}}, 8'd1};
        vecs[2].p = {{8{8'd0}}, 8'd1};
        vecs[2].bias = 32'h7FFF_FFFF;
        vecs[2].relu = 1'b0;
        vecs[2].exp  = 32'h8000_0000;
        vecs[3] = vecs[1];
        vecs[3].relu = 1'b1;
`ifdef CONV_RELU_EN
        vecs[3].exp = 32'd0;
`else
        vecs[3].exp = 32'hFFFD_C47B;
`endif
        for (int k = 4; k < 10; k++) begin
            for (int i = 0; i < 9; i++) begin
                vecs[k].w[i] = 8'($urandom);
                vecs[k].p[i] = 8'($urandom);
            end
            vecs[k].bias = $urandom;
            vecs[k].relu = 1'($urandom_range(0, 1));
            vecs[k].exp  = model(vecs[k]);
        end

        // Reset is asynchronous: outputs are clear before the first edge.
        #5;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 22; a++) begin
            bus_read(5'(a), d);
            check($sformatf("reset_reg%0d", a), d, 32'd0);
        end

        bus_write(5'd3, 32'h0000_0080);
        bus_read(5'd3, d);
        check("w3_signext", d, 32'hFFFF_FF80);
        bus_write(5'd12, 32'h1234_56F0);
        bus_read(5'd12, d);
        check("p3_signext", d, 32'hFFFF_FFF0);
        bus_write(5'd25, 32'hFFFF_FFFF);
        bus_read(5'd25, d);
        check("unmapped25", d, 32'd0);
        bus_write(5'd19, 32'h2);
        bus_read(5'd19, d);
`ifdef CONV_RELU_EN
        check("ctrl_relu_rd", d, 32'h2);
`else
        check("ctrl_relu_rd", d, 32'h0);
`endif
        bus_write(5'd19, 32'h0);

        for (int k = 0; k < 10; k++)
            run_vec(vecs[k], $sformatf("vec%0d", k));

        // Writes while busy, including a second start, must be dropped.
        load_vec(vecs[0]);
        bus_write(5'd19, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(5'd0, 32'd99);
        bus_write(5'd19, 32'h1);
        wait_done(cyc);
        check("busy_done_seen", {31'd0, irq}, 32'd1);
        bus_read(5'd21, d);
        check("busy_result", d, 32'd45);
        bus_read(5'd0, d);
        check("busy_w0_kept", d, 32'd1);
        bus_write(5'd20, 32'h2);

        // Clear write landing on the same edge that sets done.
        load_vec(vecs[2]);
        bus_write(5'd19, 32'h1);
        repeat (9) @(negedge clk);
        bus_write(5'd20, 32'h2);
        check("setwins_irq", {31'd0, irq}, 32'd1);
        bus_read(5'd20, d);
        check("setwins_status", d, 32'h2);
        bus_write(5'd20, 32'h2);
        check("clear_irq", {31'd0, irq}, 32'd0);
        bus_read(5'd20, d);
        check("clear_status", d, 32'h0);

        // Reset in the middle of MAC aborts the run.
        load_vec(vecs[0]);
        bus_write(5'd19, 32'h1);
        repeat (3) @(negedge clk);
        bus_read(5'd1, d);
        check("mac_read_w1", d, 32'd2);
        #3;
        reset = 1'b1;
        #1;
        check("abort_readdata", readdata, 32'd0);
        check("abort_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(5'd20, d);
        check("abort_status", d, 32'd0);
        bus_read(5'd21, d);
        check("abort_result", d, 32'd0);
        bus_read(5'd1, d);
        check("abort_w1", d, 32'd0);
        run_vec(vecs[0], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
